// File: rtl/mem_fetch_exec_ctrl.sv
// mem_fetch_exec_ctrl
//   Multi-cycle fetch/decode/execute sequencer for a 10-bit word memory.
//   Word format: [9:8] opcode, [7:0] operand.
//     00 HALT, 01 MOVR (R <= operand), 10 LDI (A <= mem[operand]),
//     11 LDA (A <= mem[mem[operand]]).
//   Each memory read holds mem_addr for READ_LAT cycles and samples
//   mem_data at the last edge. Any address >= MEM_DEPTH halts with err.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           begin execution at START_ADDR (only in IDLE/HALT)
//   mem_data        read data from memory
//   mem_addr,mem_rw memory address / rw (rw is always 0 = read)
//   pc, ir, mbr     program counter, instruction reg, memory buffer reg
//   acc, r_reg      accumulator A and register R
//   busy, halted    status: running / in HALT
//   err             sticky illegal-address flag (cleared by start)
//   instr_done      one-cycle pulse when an instruction retires
module mem_fetch_exec_ctrl #(
   parameter int START_ADDR = 0,
   parameter int MEM_DEPTH  = 16,
   parameter int READ_LAT   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] mem_data,
   output logic [7:0] mem_addr,
   output logic       mem_rw,
   output logic [7:0] pc,
   output logic [9:0] ir,
   output logic [9:0] mbr,
   output logic [7:0] acc,
   output logic [7:0] r_reg,
   output logic       busy,
   output logic       halted,
   output logic       err,
   output logic       instr_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_RD1, S_RD2, S_HALT
   } state_t;

   localparam int          CW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CW-1:0] LAST  = CW'(READ_LAT - 1);
   localparam logic [8:0]  DEPTH9 = (MEM_DEPTH > 256) ? 9'd256 : 9'(MEM_DEPTH);
   localparam logic [7:0]  START8 = 8'(START_ADDR);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          sample;

   function automatic logic legal(input logic [7:0] a);
      return ({1'b0, a} < DEPTH9);
   endfunction

   assign sample = (wait_cnt == LAST);
   assign mem_rw = 1'b0;
   assign busy   = (state != S_IDLE) && (state != S_HALT);
   assign halted = (state == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         pc         <= START8;
         ir         <= '0;
         mbr        <= '0;
         acc        <= '0;
         r_reg      <= '0;
         mem_addr   <= '0;
         err        <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         instr_done <= 1'b0;
         // Every state transition happens on a sample edge or from a
         // non-read state, so clearing here restarts the count on entry.
         wait_cnt   <= '0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc    <= START8;
                  err   <= 1'b0;
                  state <= S_FETCH;
                  // Address is set on entry so the read window is exactly
                  // READ_LAT cycles; an illegal pc never reaches the bus.
                  if (legal(START8)) mem_addr <= START8;
               end
            end
            S_FETCH: begin
               if (!legal(pc)) begin
                  err   <= 1'b1;
                  state <= S_HALT;
               end else if (sample) begin
                  ir    <= mem_data;
                  pc    <= pc + 8'd1;
                  state <= S_DECODE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               case (ir[9:8])
                  2'b00: begin
                     instr_done <= 1'b1;
                     state      <= S_HALT;
                  end
                  2'b01: begin
                     r_reg      <= ir[7:0];
                     instr_done <= 1'b1;
                     state      <= S_FETCH;
                     if (legal(pc)) mem_addr <= pc;
                  end
                  default: begin
                     if (!legal(ir[7:0])) begin
                        err   <= 1'b1;
                        state <= S_HALT;
                     end else begin
                        mem_addr <= ir[7:0];
                        state    <= S_RD1;
                     end
                  end
               endcase
            end
            S_RD1: begin
               if (sample) begin
                  mbr <= mem_data;
                  if (!ir[8]) begin
                     // LDI: data word bits [9:8] are dropped
                     acc        <= mem_data[7:0];
                     instr_done <= 1'b1;
                     state      <= S_FETCH;
                     if (legal(pc)) mem_addr <= pc;
                  end else if (!legal(mem_data[7:0])) begin
                     // LDA with bad pointer: acc untouched, no second read
                     err   <= 1'b1;
                     state <= S_HALT;
                  end else begin
                     mem_addr <= mem_data[7:0];
                     state    <= S_RD2;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RD2: begin
               if (sample) begin
                  mbr        <= mem_data;
                  acc        <= mem_data[7:0];
                  instr_done <= 1'b1;
                  state      <= S_FETCH;
                  if (legal(pc)) mem_addr <= pc;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fetch_exec_ctrl.sv
module tb_mem_fetch_exec_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   // DUT with READ_LAT=1
   logic       start1 = 1'b0;
   logic [9:0] mem_data1;
   logic [7:0] mem_addr1, pc1, acc1, r1;
   logic [9:0] ir1, mbr1;
   logic       rw1, busy1, halted1, err1, done1;
   logic [9:0] mem1 [16];

   // DUT with READ_LAT=3
   logic       start3 = 1'b0;
   logic [9:0] mem_data3;
   logic [7:0] mem_addr3, pc3, acc3, r3;
   logic [9:0] ir3, mbr3;
   logic       rw3, busy3, halted3, err3, done3;
   logic [9:0] mem3 [16];

   assign mem_data1 = (mem_addr1 < 8'd16) ? mem1[mem_addr1[3:0]] : 10'h3FF;
   assign mem_data3 = (mem_addr3 < 8'd16) ? mem3[mem_addr3[3:0]] : 10'h3FF;

   mem_fetch_exec_ctrl #(.START_ADDR(0), .MEM_DEPTH(16), .READ_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mem_data(mem_data1),
      .mem_addr(mem_addr1), .mem_rw(rw1), .pc(pc1), .ir(ir1), .mbr(mbr1),
      .acc(acc1), .r_reg(r1), .busy(busy1), .halted(halted1), .err(err1),
      .instr_done(done1));

   mem_fetch_exec_ctrl #(.START_ADDR(0), .MEM_DEPTH(16), .READ_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .mem_data(mem_data3),
      .mem_addr(mem_addr3), .mem_rw(rw3), .pc(pc3), .ir(ir3), .mbr(mbr3),
      .acc(acc3), .r_reg(r3), .busy(busy3), .halted(halted3), .err(err3),
      .instr_done(done3));

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard entry: one per retirement or halt event
   typedef struct {
      int         lat;
      logic [7:0] acc;
      logic [7:0] r;
      logic [9:0] mbr;
      logic [7:0] pc;
      logic       err;
      logic       hlt;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] trace [$];

   task automatic push(input int lat, input logic [7:0] a, input logic [7:0] r,
                       input logic [9:0] m, input logic [7:0] p,
                       input logic e, input logic h);
      exp_t x;
      x.lat = lat; x.acc = a; x.r = r; x.mbr = m; x.pc = p; x.err = e; x.hlt = h;
      sb.push_back(x);
   endtask

   // Monitor: latency counted from FETCH entry (busy rising or previous
   // retirement) to the event cycle.
   int   cnt = 0;
   logic busy_q = 1'b0, halted_q = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt = 0; busy_q = 1'b0; halted_q = 1'b0;
      end else begin
         if (busy1 && !busy_q) begin
            cnt = 0;
            trace.delete();
         end else cnt++;
         if (busy1) trace.push_back(mem_addr1);
         if (done1 || (halted1 && !halted_q)) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 32'(cnt), 32'hFFFF);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("latency", 32'(cnt),     32'(x.lat));
               chk("acc",     32'(acc1),    32'(x.acc));
               chk("r_reg",   32'(r1),      32'(x.r));
               chk("mbr",     32'(mbr1),    32'(x.mbr));
               chk("pc",      32'(pc1),     32'(x.pc));
               chk("err",     32'(err1),    32'(x.err));
               chk("halted",  32'(halted1), 32'(x.hlt));
            end
            if (done1) cnt = 0;
         end
         busy_q   = busy1;
         halted_q = halted1;
      end
   end

   task automatic pulse_start1();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic run_to_halt(input string name);
      int n = 0;
      while (!halted1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, 32'(n < 300), 32'd1);
      @(negedge clk);
      chk({name, "_pending"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset1(input string tag);
      chk({tag, "_pc"},   32'(pc1),   32'd0);
      chk({tag, "_ir"},   32'(ir1),   32'd0);
      chk({tag, "_mbr"},  32'(mbr1),  32'd0);
      chk({tag, "_acc"},  32'(acc1),  32'd0);
      chk({tag, "_r"},    32'(r1),    32'd0);
      chk({tag, "_addr"}, 32'(mem_addr1), 32'd0);
      chk({tag, "_flags"}, {27'd0, rw1, busy1, halted1, err1, done1}, 32'd0);
   endtask

   logic [7:0] exp3 [10];
   logic [7:0] tr3  [40];

   initial begin
      for (int i = 0; i < 16; i++) begin mem1[i] = '0; mem3[i] = '0; end
      #3;
      check_reset1("reset");
      @(negedge clk); rst_n = 1'b1;

      // MOVR 9 ; HALT
      mem1[0] = 10'h109; mem1[1] = 10'h000;
      push(2, 8'h00, 8'h09, 10'h000, 8'd1, 1'b0, 1'b0);
      push(2, 8'h00, 8'h09, 10'h000, 8'd2, 1'b0, 1'b1);
      pulse_start1();
      run_to_halt("movr");

      // LDI 10 ; HALT
      mem1[0] = 10'h20A; mem1[10] = 10'h09F;
      push(3, 8'h9F, 8'h09, 10'h09F, 8'd1, 1'b0, 1'b0);
      push(2, 8'h9F, 8'h09, 10'h09F, 8'd2, 1'b0, 1'b1);
      pulse_start1();
      run_to_halt("ldi");

      // LDA 11 -> 12 ; HALT
      mem1[0] = 10'h30B; mem1[11] = 10'h00C; mem1[12] = 10'h077;
      push(4, 8'h77, 8'h09, 10'h077, 8'd1, 1'b0, 1'b0);
      push(2, 8'h77, 8'h09, 10'h077, 8'd2, 1'b0, 1'b1);
      pulse_start1();
      run_to_halt("lda");
      chk("lda_trace0", 32'(trace[0]), 32'd0);
      chk("lda_trace1", 32'(trace[1]), 32'd0);
      chk("lda_trace2", 32'(trace[2]), 32'd11);
      chk("lda_trace3", 32'(trace[3]), 32'd12);

      // LDA with illegal pointer 0x9F: error halt, acc kept, no bad read
      mem1[11] = 10'h09F;
      push(3, 8'h77, 8'h09, 10'h09F, 8'd1, 1'b1, 1'b1);
      pulse_start1();
      run_to_halt("lda_bad");
      chk("lda_bad_addr", 32'(mem_addr1), 32'd11);

      // 16 MOVRs, then pc=16 faults in FETCH
      for (int i = 0; i < 16; i++) begin
         mem1[i] = 10'h100 | 10'(i);
         push(2, 8'h77, 8'(i), 10'h09F, 8'(i + 1), 1'b0, 1'b0);
      end
      push(1, 8'h77, 8'd15, 10'h09F, 8'd16, 1'b1, 1'b1);
      pulse_start1();
      run_to_halt("pc_off_end");

      // LDI 16: operand faults in DECODE
      mem1[0] = 10'h210;
      push(2, 8'h77, 8'd15, 10'h09F, 8'd1, 1'b1, 1'b1);
      pulse_start1();
      run_to_halt("ldi_bad");

      // restart clears err
      mem1[0] = 10'h000;
      push(2, 8'h77, 8'd15, 10'h09F, 8'd1, 1'b0, 1'b1);
      pulse_start1();
      run_to_halt("restart");

      // async reset during RD2 of an LDA
      mem1[0] = 10'h30B; mem1[11] = 10'h00C; mem1[12] = 10'h077; mem1[1] = 10'h000;
      pulse_start1();          // now in FETCH (t0)
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2;                      // inside RD2
      chk("rd2_busy", 32'(busy1), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset1("mid_reset");
      @(negedge clk); rst_n = 1'b1;

      // READ_LAT=3 LDA: 3-cycle address windows, retire 10 cycles after FETCH
      mem3[0] = 10'h30B; mem3[11] = 10'h00C; mem3[12] = 10'h077; mem3[1] = 10'h000;
      exp3 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd11, 8'd11, 8'd12, 8'd12, 8'd12};
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      begin
         int k = 0;
         while (k < 40) begin
            tr3[k] = mem_addr3;
            if (done3) break;
            @(negedge clk);
            k++;
         end
         chk("lat3_done_cycle", 32'(k), 32'd10);
         for (int i = 0; i < 10; i++) chk($sformatf("lat3_addr%0d", i), 32'(tr3[i]), 32'(exp3[i]));
         chk("lat3_acc", 32'(acc3), 32'h77);
         chk("lat3_mbr", 32'(mbr3), 32'h077);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
